// File: rtl/mdu_issue_ctrl_if.sv
// Decode/MDU-side signal bundle for mdu_issue_ctrl.
// slave = controller view, master = decode stage plus MDU driving it.
interface mdu_issue_ctrl_if;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_srca;
    logic [31:0] in_srcb;
    logic        in_ready;
    logic        req;
    logic        mdu_busy;
    logic [31:0] mdu_result;
    logic        start;
    logic        hi_write;
    logic        lo_write;
    logic        hi_read;
    logic        lo_read;
    logic [3:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        illegal_op;
    logic        stall;
    logic [15:0] stall_cycles;

    modport slave (
        input  in_valid, in_op, in_srca, in_srcb, req, mdu_busy, mdu_result,
        output in_ready, start, hi_write, lo_write, hi_read, lo_read, mdu_op,
               src_a, src_b, rd_valid, rd_data, illegal_op, stall, stall_cycles
    );

    modport master (
        output in_valid, in_op, in_srca, in_srcb, req, mdu_busy, mdu_result,
        input  in_ready, start, hi_write, lo_write, hi_read, lo_read, mdu_op,
               src_a, src_b, rd_valid, rd_data, illegal_op, stall, stall_cycles
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// Issues one MDU-class instruction at a time to the multiply/divide unit.
// Latency: accept at edge N, strobe in cycle N+1, mfhi/mflo rd_valid in cycle N+2.
// Backpressure: in_ready only in IDLE with MDU idle and no flush; else stall counted.
module mdu_issue_ctrl (
    input  logic              clk,
    input  logic              reset,
    mdu_issue_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, READ} state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] srca_q;
    logic [31:0] srcb_q;
    logic [31:0] rd_data_q;
    logic [15:0] stall_q;

    logic        in_ready_c;
    logic        accept;
    logic        stall_c;
    logic        start_c, hi_write_c, lo_write_c, hi_read_c, lo_read_c;
    logic        rd_valid_c, illegal_c;

    assign in_ready_c = (state_q == IDLE) && !bus.mdu_busy && !bus.req;
    assign accept     = bus.in_valid && in_ready_c;
    assign stall_c    = bus.in_valid && !in_ready_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = ISSUE;
            ISSUE: begin
                if (bus.req)                  state_d = IDLE;
                else if (op_q[3:2] == 2'b00)  state_d = WAIT;
                else if (op_q[3:1] == 3'b011) state_d = READ;
                else                          state_d = IDLE;
            end
            // A pending flush freezes the MDU counter, so hold here until it clears.
            WAIT:  if (!bus.mdu_busy && !bus.req) state_d = IDLE;
            READ:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_c    = 1'b0;
        hi_write_c = 1'b0;
        lo_write_c = 1'b0;
        hi_read_c  = 1'b0;
        lo_read_c  = 1'b0;
        illegal_c  = 1'b0;
        rd_valid_c = 1'b0;
        case (state_q)
            ISSUE: begin
                case (op_q)
                    4'd0, 4'd1, 4'd2, 4'd3: start_c    = 1'b1;
                    4'd4:                   hi_write_c = 1'b1;
                    4'd5:                   lo_write_c = 1'b1;
                    4'd6:                   hi_read_c  = 1'b1;
                    4'd7:                   lo_read_c  = 1'b1;
                    default:                illegal_c  = 1'b1;
                endcase
            end
            READ:    rd_valid_c = !bus.req;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= 4'd0;
            srca_q    <= 32'd0;
            srcb_q    <= 32'd0;
            rd_data_q <= 32'd0;
            stall_q   <= 16'd0;
        end else begin
            if (accept) begin
                op_q   <= bus.in_op;
                srca_q <= bus.in_srca;
                srcb_q <= bus.in_srcb;
            end
            // Capture at ISSUE exit while hi_read/lo_read holds mdu_result valid.
            if (state_q == ISSUE && !bus.req && op_q[3:1] == 3'b011) begin
                rd_data_q <= bus.mdu_result;
            end
            if (stall_c && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.stall        = stall_c;
    assign bus.stall_cycles = stall_q;
    assign bus.start        = start_c;
    assign bus.hi_write     = hi_write_c;
    assign bus.lo_write     = lo_write_c;
    assign bus.hi_read      = hi_read_c;
    assign bus.lo_read      = lo_read_c;
    assign bus.illegal_op   = illegal_c;
    assign bus.rd_valid     = rd_valid_c;
    assign bus.rd_data      = rd_data_q;
    assign bus.src_a        = srca_q;
    assign bus.src_b        = srcb_q;
    assign bus.mdu_op       = (op_q[3:2] == 2'b00) ? op_q : 4'd0;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl; a tiny HI/LO model stands in for the MDU datapath.
module tb_mdu_issue_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_issue_ctrl_if m();

    mdu_issue_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        x = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return x;
    endfunction

    assign m.mdu_result = m.hi_read ? hi_m : (m.lo_read ? lo_m : 32'd0);

    always @(posedge clk) begin
        if (m.start && !m.req) begin
            if (m.mdu_op == 4'd0)      {hi_m, lo_m} <= smul(m.src_a, m.src_b);
            else if (m.mdu_op == 4'd1) {hi_m, lo_m} <= {32'd0, m.src_a} * {32'd0, m.src_b};
        end
        if (m.hi_write && !m.req) hi_m <= m.src_a;
        if (m.lo_write && !m.req) lo_m <= m.src_a;
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        m.in_valid = 1'b1;
        m.in_op    = op;
        m.in_srca  = a;
        m.in_srcb  = b;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (m.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", m.in_ready); end
        n_cmp++; if ({m.start, m.hi_write, m.lo_write, m.hi_read, m.lo_read, m.rd_valid, m.illegal_op} !== 7'd0) begin
            n_bad++; $display("FAIL reset_strobes got %b want 0", {m.start, m.hi_write, m.lo_write, m.hi_read, m.lo_read, m.rd_valid, m.illegal_op}); end
        n_cmp++; if ({m.src_a, m.src_b, m.rd_data, m.stall_cycles, m.mdu_op} !== 116'd0) begin
            n_bad++; $display("FAIL reset_regs got %h/%h/%h/%h/%h want 0", m.src_a, m.src_b, m.rd_data, m.stall_cycles, m.mdu_op); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        @(negedge clk);
        drive(4'd0, 32'hFFFF_FFFE, 32'd3);
        @(negedge clk);
        m.in_valid = 1'b0;
        #1;
        n_cmp++; if (m.start !== 1'b1 || m.mdu_op !== 4'd0) begin n_bad++; $display("FAIL mult_start got start=%b op=%0d want 1/0", m.start, m.mdu_op); end
        n_cmp++; if (m.in_ready !== 1'b0) begin n_bad++; $display("FAIL mult_issue_ready got %b want 0", m.in_ready); end
        m.mdu_busy = 1'b1;
        @(negedge clk);
        drive(4'd7, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (m.start !== 1'b0 || m.in_ready !== 1'b0 || m.stall !== 1'b1) begin
                n_bad++; $display("FAIL mult_wait got start=%b rdy=%b stall=%b want 0/0/1", m.start, m.in_ready, m.stall); end
            @(negedge clk);
        end
        m.mdu_busy = 1'b0;
        #1;
        n_cmp++; if (m.in_ready !== 1'b0) begin n_bad++; $display("FAIL mult_wait_exit_ready got %b want 0", m.in_ready); end
        @(negedge clk);
        n_cmp++; if (m.in_ready !== 1'b1) begin n_bad++; $display("FAIL mult_idle_ready got %b want 1", m.in_ready); end
        @(negedge clk);
        m.in_valid = 1'b0;
        #1;
        n_cmp++; if (m.lo_read !== 1'b1 || m.mdu_op !== 4'd0) begin n_bad++; $display("FAIL mflo_issue got lo_read=%b op=%0d want 1/0", m.lo_read, m.mdu_op); end
        @(negedge clk);
        n_cmp++; if (m.rd_valid !== 1'b1 || m.rd_data !== 32'hFFFF_FFFA) begin
            n_bad++; $display("FAIL mflo_read got v=%b d=%h want 1/fffffffa", m.rd_valid, m.rd_data); end
        @(negedge clk);
        n_cmp++; if (m.rd_valid !== 1'b0 || m.rd_data !== 32'hFFFF_FFFA) begin
            n_bad++; $display("FAIL mflo_after got v=%b d=%h want 0/fffffffa", m.rd_valid, m.rd_data); end
    endtask

    task automatic test_back_to_back();
        drive(4'd4, 32'h1234_5678, 32'd0);
        @(negedge clk);
        drive(4'd6, 32'd0, 32'd0);
        #1;
        n_cmp++; if ({m.start, m.hi_write, m.lo_write, m.hi_read, m.lo_read} !== 5'b01000) begin
            n_bad++; $display("FAIL mthi_issue got %b want 01000", {m.start, m.hi_write, m.lo_write, m.hi_read, m.lo_read}); end
        @(negedge clk);
        n_cmp++; if (m.hi_write !== 1'b0 || m.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL mthi_idle got hw=%b rdy=%b want 0/1", m.hi_write, m.in_ready); end
        @(negedge clk);
        m.in_valid = 1'b0;
        #1;
        n_cmp++; if (m.hi_read !== 1'b1 || m.rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL mfhi_issue got hr=%b v=%b want 1/0", m.hi_read, m.rd_valid); end
        @(negedge clk);
        n_cmp++; if (m.rd_valid !== 1'b1 || m.rd_data !== 32'h1234_5678 || m.hi_read !== 1'b0) begin
            n_bad++; $display("FAIL mfhi_read got v=%b d=%h hr=%b want 1/12345678/0", m.rd_valid, m.rd_data, m.hi_read); end
        @(negedge clk);
    endtask

    task automatic test_req_issue();
        drive(4'd4, 32'hCAFE_F00D, 32'd0);
        @(negedge clk);
        m.in_valid = 1'b0;
        @(negedge clk);
        drive(4'd6, 32'd0, 32'd0);
        @(negedge clk);
        m.in_valid = 1'b0;
        m.req = 1'b1;
        #1;
        n_cmp++; if (m.hi_read !== 1'b1 || m.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL req_issue_strobe got hr=%b rdy=%b want 1/0", m.hi_read, m.in_ready); end
        @(negedge clk);
        m.req = 1'b0;
        #1;
        n_cmp++; if (m.rd_valid !== 1'b0 || m.rd_data !== 32'h1234_5678 || m.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL req_issue_flush got v=%b d=%h rdy=%b want 0/12345678/1", m.rd_valid, m.rd_data, m.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        drive(4'd9, 32'h5555_AAAA, 32'd1);
        @(negedge clk);
        m.in_valid = 1'b0;
        #1;
        n_cmp++; if (m.illegal_op !== 1'b1 || {m.start, m.hi_write, m.lo_write, m.hi_read, m.lo_read} !== 5'd0 || m.mdu_op !== 4'd0) begin
            n_bad++; $display("FAIL illegal_issue got ill=%b str=%b op=%0d want 1/0/0", m.illegal_op,
                {m.start, m.hi_write, m.lo_write, m.hi_read, m.lo_read}, m.mdu_op); end
        @(negedge clk);
        n_cmp++; if (m.illegal_op !== 1'b0 || m.in_ready !== 1'b1 || m.rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL illegal_after got ill=%b rdy=%b v=%b want 0/1/0", m.illegal_op, m.in_ready, m.rd_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(4'd2, 32'd100, 32'd7);
        @(negedge clk);
        m.in_valid = 1'b0;
        m.mdu_busy = 1'b1;
        #1;
        n_cmp++; if (m.start !== 1'b1 || m.mdu_op !== 4'd2 || m.src_a !== 32'd100 || m.src_b !== 32'd7) begin
            n_bad++; $display("FAIL div_issue got s=%b op=%0d a=%0d b=%0d want 1/2/100/7", m.start, m.mdu_op, m.src_a, m.src_b); end
        @(negedge clk);
        drive(4'd7, 32'd0, 32'd0);
        for (int i = 0; i < 7; i++) begin
            #1;
            n_cmp++; if (m.stall !== 1'b1) begin n_bad++; $display("FAIL div_stall_%0d got %b want 1", i, m.stall); end
            @(negedge clk);
        end
        m.in_valid = 1'b0;
        #1;
        n_cmp++; if (m.stall_cycles !== 16'd7 || m.stall !== 1'b0) begin
            n_bad++; $display("FAIL stall_count got %0d stall=%b want 7/0", m.stall_cycles, m.stall); end
        m.mdu_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_req_wait();
        drive(4'd0, 32'd7, 32'd6);
        @(negedge clk);
        m.in_valid = 1'b0;
        m.mdu_busy = 1'b1;
        @(negedge clk);
        m.mdu_busy = 1'b0;
        m.req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m.req = 1'b0;
        #1;
        n_cmp++; if (m.in_ready !== 1'b0) begin n_bad++; $display("FAIL req_wait_hold got rdy=%b want 0", m.in_ready); end
        @(negedge clk);
        n_cmp++; if (m.in_ready !== 1'b1) begin n_bad++; $display("FAIL req_wait_exit got rdy=%b want 1", m.in_ready); end
        drive(4'd7, 32'd0, 32'd0);
        @(negedge clk);
        m.in_valid = 1'b0;
        @(negedge clk);
        m.req = 1'b1;
        #1;
        n_cmp++; if (m.rd_valid !== 1'b0 || m.rd_data !== 32'd42) begin
            n_bad++; $display("FAIL req_read got v=%b d=%0d want 0/42", m.rd_valid, m.rd_data); end
        @(negedge clk);
        m.req = 1'b0;
        #1;
        n_cmp++; if (m.in_ready !== 1'b1 || m.rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL req_read_exit got rdy=%b v=%b want 1/0", m.in_ready, m.rd_valid); end
    endtask

    task automatic test_reset_mid();
        drive(4'd0, 32'd5, 32'd5);
        @(negedge clk);
        m.mdu_busy = 1'b1;
        drive(4'd5, 32'hA5A5_0001, 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if ({m.start, m.hi_write, m.lo_write, m.hi_read, m.lo_read, m.rd_valid, m.illegal_op} !== 7'd0 ||
                     m.src_a !== 32'd0 || m.src_b !== 32'd0 || m.rd_data !== 32'd0 || m.stall_cycles !== 16'd0 || m.mdu_op !== 4'd0) begin
            n_bad++; $display("FAIL reset_mid got a=%h b=%h d=%h sc=%0d want 0", m.src_a, m.src_b, m.rd_data, m.stall_cycles); end
        m.mdu_busy = 1'b0;
        #1;
        n_cmp++; if (m.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid_idle got rdy=%b want 1", m.in_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m.in_valid = 1'b0;
        #1;
        n_cmp++; if (m.lo_write !== 1'b1 || m.src_a !== 32'hA5A5_0001 || m.start !== 1'b0) begin
            n_bad++; $display("FAIL reset_first_accept got lw=%b a=%h s=%b want 1/a5a50001/0", m.lo_write, m.src_a, m.start); end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        do_reset();
        m.mdu_busy = 1'b1;
        drive(4'd6, 32'd0, 32'd0);
        repeat (65534) @(negedge clk);
        n_cmp++; if (m.stall_cycles !== 16'hFFFE) begin n_bad++; $display("FAIL sat_fffe got %h want fffe", m.stall_cycles); end
        @(negedge clk);
        n_cmp++; if (m.stall_cycles !== 16'hFFFF) begin n_bad++; $display("FAIL sat_ffff got %h want ffff", m.stall_cycles); end
        repeat (5) @(negedge clk);
        n_cmp++; if (m.stall_cycles !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got %h want ffff", m.stall_cycles); end
        m.in_valid = 1'b0;
        m.mdu_busy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        m.in_valid = 1'b0;
        m.in_op    = 4'd0;
        m.in_srca  = 32'd0;
        m.in_srcb  = 32'd0;
        m.req      = 1'b0;
        m.mdu_busy = 1'b0;
        test_reset();
        test_mult();
        test_back_to_back();
        test_req_issue();
        test_illegal();
        test_stall();
        test_req_wait();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
